fetch_buffer: RTL and testbench

Parametrised instruction-fetch stage with a program counter, an in-order instruction-memory request/response interface and a DEPTH-entry prefetch queue. It feeds decode through a valid/ready handshake, which replaces the single-register stall/flush fetch stage. Flush with redirect discards queued and in-flight instructions and restarts fetch at a new PC. Fetch keeps running while decode stalls until the queue and in-flight credit are exhausted.

---
 rtl/fetch_buffer.sv | 93 +++++++++
 tb/tb_fetch_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: PC generator, in-order imem request/response port and a
// DEPTH-entry prefetch queue feeding decode; flush redirects and discards in-flight work.
module fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high (imem_req_o/imem_ready_i, valid_o/ready_i); valid never depends on ready.
    logic [XLEN-1:0] req_pc, resp_pc;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, outstanding, discard;

    logic          accept, resp, push, drop, pop;
    logic [CW:0]   used;
    logic [CW-1:0] flush_out;
    logic [XLEN-1:0] redirect_aligned;

    assign used             = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o       = !rst && !flush_i && (used < (CW+1)'(DEPTH));
    assign imem_addr_o      = req_pc;
    assign accept           = imem_req_o && imem_ready_i;
    // Responses with nothing outstanding are stray and leave state untouched.
    assign resp             = imem_rvalid_i && (outstanding != '0);
    assign drop             = resp && (discard != '0) && !flush_i;
    assign push             = resp && (discard == '0) && !flush_i;
    assign valid_o          = (count != '0) && !flush_i;
    assign pop              = valid_o && ready_i;
    assign flush_out        = outstanding - {{(CW-1){1'b0}}, resp};
    assign redirect_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

    assign instr_o = valid_o ? q_instr[head] : '0;
    assign pc_o    = valid_o ? q_pc[head]    : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc      <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (flush_i) begin
            // Every request still in flight returns later and must be thrown away.
            req_pc      <= redirect_aligned;
            resp_pc     <= redirect_aligned;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= flush_out;
            discard     <= flush_out;
        end else begin
            if (accept) req_pc <= req_pc + STEP;
            if (push) begin
                resp_pc <= resp_pc + STEP;
                tail    <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            if (drop) discard <= discard - 1'b1;
            outstanding <= outstanding + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, resp};
            count       <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    // Queue storage carries no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= resp_pc;
            q_instr[tail] <= imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: memory model with configurable latency, expected-PC queue
// filled at request accept and drained by an independent decode-side monitor.
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    fetch_buffer #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .flush_i(flush_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mem_req_t;

    logic [31:0] exp_q[$];
    mem_req_t    mem_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          first_req_cyc = -1;
    int          first_valid_cyc = -1;
    int          acc_count = 0;
    int          lat_min = 1, lat_max = 1;
    bit          rdy_rand = 0, mem_stop = 0;
    logic [31:0] next_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: in-order responses, latency drawn per request, content = ~addr.
    initial begin
        imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (rst) begin
                mem_q.delete();
                imem_rvalid_i = 1'b0;
                imem_ready_i  = 1'b0;
            end else begin
                if (mem_q.size() > 0 && mem_q[0].due <= 32'(cyc)) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = ~mem_q[0].addr;
                    void'(mem_q.pop_front());
                end else begin
                    imem_rvalid_i = 1'b0;
                    imem_rdata_i  = 32'hDEAD_BEEF;
                end
                imem_ready_i = mem_stop ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
                #1;
                if (imem_req_o && imem_ready_i) begin
                    chk("req_addr", imem_addr_o, next_addr);
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    exp_q.push_back(next_addr);
                    mem_q.push_back('{addr: next_addr,
                                      due: 32'(cyc + $urandom_range(lat_min, lat_max))});
                    next_addr = next_addr + 32'd4;
                    acc_count++;
                end
            end
        end
    end

    // Decode-side monitor: every accepted instruction must match the head of exp_q.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (valid_o) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (ready_i) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_pop", pc_o, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pop_pc", pc_o, e);
                            chk("pop_instr", instr_o, ~e);
                        end
                    end
                end else begin
                    chk("idle_outputs", instr_o | pc_o, 32'h0);
                end
            end
        end
    end

    task automatic do_flush(input logic [31:0] pc, input logic rdy);
        @(negedge clk);
        flush_i       = 1'b1;
        redirect_pc_i = pc;
        ready_i       = rdy;
        exp_q.delete();
        next_addr     = {pc[31:2], 2'b00};
        #3;
        chk("flush_valid", {31'b0, valid_o}, 32'h0);
        chk("flush_req", {31'b0, imem_req_o}, 32'h0);
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    initial begin
        logic [31:0] held_pc;
        int acc_base;
        int budget;
        rst = 1'b1; flush_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req", {31'b0, imem_req_o}, 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;

        // Streaming with 1-cycle memory.
        repeat (14) @(negedge clk);
        chk("first_req_cycle", 32'(first_req_cyc - rel_cyc), 32'd1);
        chk("first_valid_cycle", 32'(first_valid_cyc - rel_cyc), 32'd3);

        // Flush alongside a response and a ready decode; misaligned target.
        do_flush(32'h0000_0202, 1'b1);
        repeat (6) @(negedge clk);

        // Decode stall straight after a flush: credit caps requests at DEPTH.
        do_flush(32'h0000_0300, 1'b0);
        acc_base = acc_count;
        repeat (3) @(negedge clk);
        #3 held_pc = pc_o;
        repeat (6) @(negedge clk);
        #3;
        chk("stall_accepts", 32'(acc_count - acc_base), 32'd4);
        chk("stall_req_low", {31'b0, imem_req_o}, 32'h0);
        chk("stall_valid", {31'b0, valid_o}, 32'h1);
        chk("stall_pc_stable", pc_o, held_pc);
        chk("stall_head_pc", pc_o, 32'h0000_0300);
        chk("stall_head_instr", instr_o, ~32'h0000_0300);
        @(negedge clk);
        ready_i = 1'b1;
        repeat (8) @(negedge clk);

        // Slow memory with decode stalled, then flush with stale requests in flight.
        ready_i = 1'b0; lat_min = 3; lat_max = 3;
        repeat (3) @(negedge clk);
        do_flush(32'h0000_0100, 1'b1);
        repeat (8) @(negedge clk);

        // Random memory acceptance, latency and decode stalls.
        lat_min = 1; lat_max = 3; rdy_rand = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ready_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        ready_i = 1'b1; rdy_rand = 0; lat_min = 1; lat_max = 1;
        repeat (4) @(negedge clk);

        // Address wrap at the top of the space.
        do_flush(32'hFFFF_FFF8, 1'b1);
        repeat (10) @(negedge clk);

        // Drain: stop accepting requests and let everything reach decode.
        mem_stop = 1;
        budget = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        #3;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", {31'b0, valid_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
